deadtime_gen: RTL

DEADTIME_GEN -- requirements
Module: deadtime_gen

---
 rtl/deadtime_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/deadtime_gen.sv
// Dead-time generator for a half-bridge gate driver.
//
// Turns a single modulated command (pwm_in) into complementary high-side and
// low-side gate drives. Both drives are held low for DEAD_TIME cycles on every
// commutation. A synchronous fault input latches the block into a safe state
// with both drives low, until fault_clr is asserted.
//
// Ports:
//   clk           - clock, rising-edge active
//   rst           - asynchronous active-high reset
//   pwm_in        - modulated command, 1 = high side on
//   fault         - synchronous fault request, active-high
//   fault_clr     - synchronous fault-latch clear, active-high
//   hs_out        - high-side gate drive (registered)
//   ls_out        - low-side gate drive (registered)
//   fault_latched - 1 while held in the fault state (registered)
//   dt_active     - 1 while a dead-time interval is running (registered)
module deadtime_gen #(
    parameter int unsigned DEAD_TIME = 10,
    parameter int unsigned CNT_WIDTH = $clog2(DEAD_TIME + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    input  logic fault,
    input  logic fault_clr,
    output logic hs_out,
    output logic ls_out,
    output logic fault_latched,
    output logic dt_active
);

    typedef enum logic [2:0] {
        StLow,
        StDtRise,
        StHigh,
        StDtFall,
        StFault
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DtLoad = CNT_WIDTH'(DEAD_TIME);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pwm_q;

    // Next-state and counter logic. The counter is zero outside the dead-time
    // states, so it can never underflow.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (fault) begin
            state_d = StFault;
            cnt_d   = '0;
        end else begin
            unique case (state)
                StLow: begin
                    cnt_d = '0;
                    if (pwm_q) begin
                        state_d = StDtRise;
                        cnt_d   = DtLoad;
                    end
                end
                StDtRise: begin
                    if (!pwm_q) begin
                        // Command withdrawn before the high side turned on.
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (cnt <= CntOne) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt - CntOne;
                    end
                end
                StHigh: begin
                    cnt_d = '0;
                    if (!pwm_q) begin
                        state_d = StDtFall;
                        cnt_d   = DtLoad;
                    end
                end
                StDtFall: begin
                    if (pwm_q) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (cnt <= CntOne) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt - CntOne;
                    end
                end
                StFault: begin
                    cnt_d = '0;
                    if (fault_clr) begin
                        state_d = StDtFall;
                        cnt_d   = DtLoad;
                    end
                end
                default: begin
                    state_d = StFault;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state and come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StDtFall;
            cnt           <= DtLoad;
            pwm_q         <= 1'b0;
            hs_out        <= 1'b0;
            ls_out        <= 1'b0;
            fault_latched <= 1'b0;
            dt_active     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            pwm_q         <= pwm_in;
            hs_out        <= (state_d == StHigh);
            ls_out        <= (state_d == StLow);
            fault_latched <= (state_d == StFault);
            dt_active     <= (state_d == StDtRise) || (state_d == StDtFall);
        end
    end

endmodule
